alu_mux_sched: RTL
==================

# alu_mux_sched

Round-robin scheduler that shares the single 33-bit-output ALU mux datapath between `NREQ` requesters. Each requester presents operands A/B and a 4-bit op select with a valid/ready handshake. The scheduler grants one request at a time and drives the ALU's `A`/`B`/`sel_i`/`enb` from registers. It samples the ALU result and returns it, tagged with the requester ID, on a single response channel with backpressure.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: requester ID width; must equal clog2(`NREQ`).
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  accept strobe; at most one bit high.
- `req_a`  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B, packed the same way.
- `req_sel`  in  4*NREQ  op select; requester i uses bits [4i+3:4i].
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_sel`  out  4  registered op select to the ALU.
- `alu_enb`  out  1  ALU enable; high only in EXEC.
- `alu_out`  in  33  combinational ALU result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  IDW  ID of the requester being answered.
- `rsp_data`  out  33  result.
- `rsp_err`  out  1  1 = invalid op select (7..15).
- `op_cnt`  out  16  count of completed responses; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search `req_valid` starting at round-robin pointer `ptr` (wrapping) for the first set bit `g`.
  - If found, `req_ready[g]`=1 combinationally; the transfer completes on that clock edge.
  - At the transfer edge: capture `req_a`/`req_b`/`req_sel` of `g` into `alu_a`/`alu_b`/`alu_sel`, capture `rsp_id`=`g`, and set `ptr` = (`g`+1) mod `NREQ`.
  - If the captured sel ≤ 6, go to EXEC.
  - If the captured sel is 7..15, go directly to RESP with `rsp_err`=1 and `rsp_data`=0; `alu_enb` is never asserted for that transaction.
- EXEC (one cycle):
  - `alu_enb`=1.
  - At the end of the cycle, register `alu_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` stay stable until `rsp_valid && rsp_ready`.
  - On handshake: `rsp_valid`=0, `op_cnt`+1, return to IDLE.
- `req_ready` is 0 in EXEC and RESP, so no new request is accepted while one is outstanding.
- Requesters must hold valid and payload stable until ready.
- `alu_a`, `alu_b` and `alu_sel` hold their last values outside EXEC.
- Expected results (33-bit, ALU's arithmetic):
  - sel 0 → A&B; 1 → A−B with 33-bit wrap; 2 → A+B with carry in bit 32.
  - sel 3 → A*A, low 33 bits; 4 → B*B, low 33 bits.
  - sel 5 → A&0xFFFF; 6 → 0.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `ptr`=0, `op_cnt`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_id`=0, `rsp_data`=0.
  - `alu_a`=0, `alu_b`=0, `alu_sel`=0, `alu_enb`=0.
  - `req_ready`=0 while `rstn`=0.
- Latency, accept edge to `rsp_valid` high:
  - valid op: 2 cycles.
  - invalid op: 1 cycle.
- Peak throughput (`rsp_ready` tied high):
  - valid ops: one every 3 cycles.
  - invalid ops: one every 2 cycles.
- `rsp_ready` already high when `rsp_valid` rises: the handshake completes in that same cycle.
- Response handshake and new requests waiting: the next grant happens in the IDLE cycle that follows; there is no IDLE bypass.
- Reset mid-transaction: the transaction is dropped with no response and `op_cnt` is not incremented.
- A single requester with continuous valid is re-granted every transaction.
- The pointer only advances on a grant.

## Test plan
- Single op: req1 with sel=2, A=5, B=7 → `req_ready[1]` for 1 cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=1, `rsp_data`=12, `rsp_err`=0; `op_cnt`=1 after the handshake.
- Width edge cases:
  - sel=1, A=3, B=5 → `rsp_data`=0x1_FFFF_FFFE.
  - sel=3, A=0x0001_0000 → `rsp_data`=0x1_0000_0000.
  - sel=2, A=B=0xFFFF_FFFF → `rsp_data`=0x1_FFFF_FFFE.
- Fairness: all 4 requesters valid from reset, `rsp_ready`=1 → grant/response order 0,1,2,3,0; no `req_ready` overlap.
- Invalid op: sel=9 → `rsp_valid` 1 cycle after accept, `rsp_err`=1, `rsp_data`=0, `alu_enb` never high.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during RESP → response fields stable; no `req_ready` pulse to other valid requesters until the handshake.
- Reset: drop `rstn` during EXEC → all outputs at reset values immediately; no response emitted; `op_cnt`=0.

Source files
------------

// File: rtl/alu_mux_sched_if.sv
// Request/response bundle between the requesters and the ALU mux scheduler.
// The requester side is the master; the scheduler is the slave.
interface alu_mux_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]    req_sel;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [32:0]          rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_mux_sched.sv
// Round-robin scheduler sharing one 33-bit ALU mux between NREQ requesters,
// returning tagged results on a single backpressured response channel.
//
// state | meaning
// IDLE  | search req_valid from ptr, accept the first valid requester
// EXEC  | alu_enb high for one cycle, result registered at the end
// RESP  | rsp_valid high, fields held until rsp_ready
module alu_mux_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    alu_mux_sched_if.slave    bus,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_sel,
    output logic              alu_enb,
    input  logic [32:0]       alu_out,
    output logic [15:0]       op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  ptr_next;
    logic            gnt_found;
    logic [IDW:0]    scan;
    logic [NREQ-1:0] ready;

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [32:0]     rsp_data_q;
    logic            rsp_err_q;

    logic [31:0]     a_arr   [NREQ];
    logic [31:0]     b_arr   [NREQ];
    logic [3:0]      sel_arr [NREQ];

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_unpack
            assign a_arr[i]   = bus.req_a[32*i +: 32];
            assign b_arr[i]   = bus.req_b[32*i +: 32];
            assign sel_arr[i] = bus.req_sel[4*i +: 4];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + k[IDW:0];
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!gnt_found && bus.req_valid[scan[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan[IDW-1:0];
            end
        end
    end

    assign ptr_next = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);

    always_comb begin
        ready = '0;
        if (rstn && state == IDLE && gnt_found) begin
            ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= '0;
            op_cnt      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            alu_enb     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        alu_a    <= a_arr[gnt_id];
                        alu_b    <= b_arr[gnt_id];
                        alu_sel  <= sel_arr[gnt_id];
                        rsp_id_q <= gnt_id;
                        ptr      <= ptr_next;
                        if (sel_arr[gnt_id] <= 4'd6) begin
                            alu_enb <= 1'b1;
                            state   <= EXEC;
                        end else begin
                            // Unsupported op: answer with an error, never touch the ALU.
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                EXEC: begin
                    alu_enb     <= 1'b0;
                    rsp_data_q  <= alu_out;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt      <= op_cnt + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
